mem_port_ctrl: RTL and testbench
================================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, BRAM word-address width; data width is fixed at 16.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  1  request strobe from the datapath.
REQ-005 SHALL have port we  input  1  1=store, 0=load.
REQ-006 SHALL have port size  input  1  0=16-bit word, 1=byte.
REQ-007 SHALL have port sign  input  1  byte load: 1=sign-extend, 0=zero-extend.
REQ-008 SHALL have port addr  input  ADDR_WIDTH+1  byte address; word = addr[ADDR_WIDTH:1], lane = addr[0] (0=bits 7:0).
REQ-009 SHALL have port wdata  input  16  store data; byte stores use wdata[7:0].
REQ-010 SHALL have port ready  output  1  high only in IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  16  registered load result.
REQ-013 SHALL have ports mem_addr  output  ADDR_WIDTH, mem_wdata  output  16, mem_we  output  1, mem_rdata  input  16: one port of the synchronous-read BRAM (q valid one edge after address sampled).

Function
REQ-014 SHALL accept a request on a rising edge where req=1 and ready=1, latching we, size, sign, addr, wdata; input changes afterwards SHALL NOT affect the operation.
REQ-015 SHALL ignore req while ready=0; no queuing.
REQ-016 SHALL implement states IDLE, FETCH, WAIT, STORE, RESP.
REQ-017 Word store: IDLE->STORE->IDLE; done and mem_we high in the first cycle after acceptance.
REQ-018 Load (word or byte): IDLE->FETCH->WAIT->RESP->IDLE; rdata captured from mem_rdata at end of WAIT; done high in RESP (third cycle after acceptance).
REQ-019 Byte store (read-modify-write): IDLE->FETCH->WAIT->STORE->IDLE; merge at end of WAIT replaces only the addressed lane with wdata[7:0]; STORE writes merged word; done in third cycle after acceptance.
REQ-020 mem_addr SHALL equal latched word address in FETCH, WAIT, STORE, RESP; 0 in IDLE.
REQ-021 mem_we SHALL be 1 only in STORE, exactly one cycle per store; mem_wdata SHALL be 0 whenever mem_we=0.
REQ-022 Byte load: rdata = selected lane in [7:0], [15:8] = lane bit 7 if sign=1 else 0; sign ignored for word loads and all stores.
REQ-023 rdata SHALL hold its value until the next load completes; stores SHALL NOT modify it.
REQ-024 done SHALL be high only in STORE or RESP; earliest next acceptance is the edge after the done cycle.
REQ-025 Address wrap: no range checking; top word address (all ones) SHALL behave as any other.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, ready=1, done=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, clearing latched request and merge registers.
REQ-027 reset asserted mid-operation (including during STORE) SHALL abort with no further write; an operation aborted before STORE SHALL leave memory unchanged.
REQ-028 First acceptance SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-029 Word store 0x000F to byte addr 0x000, then word load 0x000 -> mem_we pulses 1 cycle after accept; load done 3 cycles after accept, rdata=0x000F.
REQ-030 Word store 0x3000 to byte addr 0x004; byte store 0xAB to 0x005; word load 0x004 -> rdata=0xAB00, done 3 cycles after each byte-store accept.
REQ-031 Word store 0x80F0 to 0x006; byte load 0x006 sign=1 -> 0xFFF0; byte load 0x007 sign=0 -> 0x0080; sign=1 -> 0xFF80.
REQ-032 req held high during load -> exactly one operation; ready=0 for FETCH/WAIT/RESP; second accept the edge after done.
REQ-033 reset pulsed during WAIT of byte store to 0x000 (word 0x000F) -> no mem_we, outputs at reset values, subsequent load returns 0x000F.
REQ-034 Store 0x1234 to top byte address 0x7FE (ADDR_WIDTH=10) and load back -> mem_addr=0x3FF, rdata=0x1234.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// Single-port BRAM access controller: word/byte loads and stores, byte stores done as
// read-modify-write against a synchronous-read memory.
module mem_port_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic                  size,
  input  logic                  sign,
  input  logic [ADDR_WIDTH:0]   addr,
  input  logic [15:0]           wdata,
  output logic                  ready,
  output logic                  done,
  output logic [15:0]           rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [15:0]           mem_rdata
);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StStore, StResp} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  size_q, size_d;
  logic                  sign_q, sign_d;
  logic [ADDR_WIDTH:0]   addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [15:0]           merge_q, merge_d;
  logic [15:0]           rdata_q, rdata_d;

  logic                  accept;
  logic [7:0]            lane_byte;

  assign accept    = req && (state_q == StIdle);
  assign lane_byte = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req) state_d = (we && !size) ? StStore : StFetch;
      StFetch: state_d = StWait;
      StWait:  state_d = we_q ? StStore : StResp;
      StStore: state_d = StIdle;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    if (accept) begin
      we_d    = we;
      size_d  = size;
      sign_d  = sign;
      addr_d  = addr;
      wdata_d = wdata;
    end
    // mem_rdata is valid in WAIT: merge for a byte store, capture for a load.
    if (state_q == StWait) begin
      if (we_q) begin
        merge_d = addr_q[0] ? {wdata_q[7:0], mem_rdata[7:0]} : {mem_rdata[15:8], wdata_q[7:0]};
      end else if (size_q) begin
        rdata_d = {{8{sign_q & lane_byte[7]}}, lane_byte};
      end else begin
        rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 1'b0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ready     = (state_q == StIdle);
    done      = (state_q == StStore) || (state_q == StResp);
    mem_we    = (state_q == StStore);
    mem_addr  = ready ? '0 : addr_q[ADDR_WIDTH:1];
    mem_wdata = '0;
    if (mem_we) mem_wdata = size_q ? merge_q : wdata_q;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed scenarios plus randomized ops against a
// word-array memory model.
module tb_mem_port_ctrl;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, we, size, sign;
  logic [AW:0]   addr;
  logic [15:0]   wdata;
  logic          ready, done;
  logic [15:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we;
  logic [15:0]   mem_rdata;

  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [15:0]   bd_data;
  logic [15:0]   bram [WORDS];

  logic [15:0]   ref_mem [WORDS];
  logic [15:0]   exp_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign      (sign),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Synchronous-read BRAM with a backdoor preload port.
  always @(posedge clk) begin
    if (bd_we) bram[bd_addr] <= bd_data;
    else if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  // Reference: apply one operation to the word array, return the expected rdata afterwards.
  task automatic model_apply(input logic m_we, input logic m_size, input logic m_sign,
                             input logic [AW:0] m_addr, input logic [15:0] m_wdata,
                             output logic [15:0] exp_rd);
    int w;
    int lane;
    logic [7:0] b;
    w    = int'(m_addr >> 1);
    lane = int'(m_addr[0]);
    if (m_we) begin
      if (m_size) ref_mem[w][lane*8 +: 8] = m_wdata[7:0];
      else ref_mem[w] = m_wdata;
    end else if (m_size) begin
      b = ref_mem[w][lane*8 +: 8];
      exp_rdata = {(m_sign && b[7]) ? 8'hFF : 8'h00, b};
    end else begin
      exp_rdata = ref_mem[w];
    end
    exp_rd = exp_rdata;
  endtask

  // Drives one request from a negedge, scrambles inputs after acceptance, observes to done.
  task automatic do_op(input logic op_we, input logic op_size, input logic op_sign,
                       input logic [AW:0] op_addr, input logic [15:0] op_wdata,
                       output int lat, output int we_cnt, output int busy_rdy,
                       output logic leak, output logic [15:0] rd, output logic [AW-1:0] ma,
                       output logic idle_ok);
    logic [31:0] r;
    req = 1'b1; we = op_we; size = op_size; sign = op_sign; addr = op_addr; wdata = op_wdata;
    @(posedge clk);
    #1;
    r = $urandom;
    req = 1'b0; we = r[0]; size = r[1]; sign = r[2]; addr = r[AW+3:3]; wdata = r[31:16];
    lat = -1; we_cnt = 0; busy_rdy = 0; leak = 1'b0; rd = '0; ma = '0; idle_ok = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (!mem_we && mem_wdata != 16'h0) leak = 1'b1;
      if (ready) busy_rdy++;
      if (done) begin
        lat = c;
        rd  = rdata;
        ma  = mem_addr;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (!mem_we && mem_wdata != 16'h0) leak = 1'b1;
      idle_ok = ready && !done && (mem_addr == '0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 1'b1; we = 1'b1; size = 1'b0; addr = 11'h002; wdata = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (!(ready === 1'b1 && done === 1'b0 && mem_we === 1'b0)) begin
      failures++;
      $display("FAIL reset_ctl: ready=%b done=%b mem_we=%b want 1 0 0", ready, done, mem_we);
    end
    checks++;
    if (rdata !== 16'h0 || mem_addr !== '0 || mem_wdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h want 0 0 0",
               rdata, mem_addr, mem_wdata);
    end
    req = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_word_store_load();
    int lat, wc, br; logic lk, io; logic [15:0] rd, er; logic [AW-1:0] ma;
    // Acceptance on the first edge after reset release.
    model_apply(1'b1, 1'b0, 1'b0, 11'h000, 16'h000F, er);
    do_op(1'b1, 1'b0, 1'b0, 11'h000, 16'h000F, lat, wc, br, lk, rd, ma, io);
    checks++;
    if (lat !== 1 || wc !== 1) begin
      failures++;
      $display("FAIL wstore_timing: lat=%0d we_pulses=%0d want 1 1", lat, wc);
    end
    checks++;
    if (lk || !io) begin
      failures++;
      $display("FAIL wstore_idle: wdata_leak=%b idle_ok=%b want 0 1", lk, io);
    end
    model_apply(1'b0, 1'b0, 1'b0, 11'h000, 16'h0, er);
    do_op(1'b0, 1'b0, 1'b0, 11'h000, 16'h0, lat, wc, br, lk, rd, ma, io);
    checks++;
    if (lat !== 3 || wc !== 0 || br !== 0) begin
      failures++;
      $display("FAIL wload_timing: lat=%0d we=%0d ready_busy=%0d want 3 0 0", lat, wc, br);
    end
    checks++;
    if (rd !== 16'h000F) begin
      failures++;
      $display("FAIL wload_data: got %h want 000f", rd);
    end
  endtask

  task automatic test_byte_store();
    int lat, wc, br; logic lk, io; logic [15:0] rd, er; logic [AW-1:0] ma;
    model_apply(1'b1, 1'b0, 1'b0, 11'h004, 16'h3000, er);
    do_op(1'b1, 1'b0, 1'b0, 11'h004, 16'h3000, lat, wc, br, lk, rd, ma, io);
    model_apply(1'b1, 1'b1, 1'b0, 11'h005, 16'h12AB, er);
    do_op(1'b1, 1'b1, 1'b0, 11'h005, 16'h12AB, lat, wc, br, lk, rd, ma, io);
    checks++;
    if (lat !== 3 || wc !== 1 || br !== 0) begin
      failures++;
      $display("FAIL bstore_timing: lat=%0d we=%0d ready_busy=%0d want 3 1 0", lat, wc, br);
    end
    checks++;
    if (rd !== 16'h000F || lk) begin
      failures++;
      $display("FAIL bstore_hold: rdata=%h leak=%b want 000f 0", rd, lk);
    end
    model_apply(1'b0, 1'b0, 1'b0, 11'h004, 16'h0, er);
    do_op(1'b0, 1'b0, 1'b0, 11'h004, 16'h0, lat, wc, br, lk, rd, ma, io);
    checks++;
    if (rd !== 16'hAB00) begin
      failures++;
      $display("FAIL bstore_merge: got %h want ab00", rd);
    end
  endtask

  task automatic test_byte_load_sign();
    int lat, wc, br; logic lk, io; logic [15:0] rd, er; logic [AW-1:0] ma;
    logic [AW:0]  la [3];
    logic         ls [3];
    logic [15:0]  lw [3];
    la = '{11'h006, 11'h007, 11'h007};
    ls = '{1'b1, 1'b0, 1'b1};
    lw = '{16'hFFF0, 16'h0080, 16'hFF80};
    model_apply(1'b1, 1'b0, 1'b0, 11'h006, 16'h80F0, er);
    do_op(1'b1, 1'b0, 1'b0, 11'h006, 16'h80F0, lat, wc, br, lk, rd, ma, io);
    for (int i = 0; i < 3; i++) begin
      model_apply(1'b0, 1'b1, ls[i], la[i], 16'h0, er);
      do_op(1'b0, 1'b1, ls[i], la[i], 16'h0, lat, wc, br, lk, rd, ma, io);
      checks++;
      if (rd !== lw[i] || lat !== 3) begin
        failures++;
        $display("FAIL bload_%0d: rdata=%h lat=%0d want %h 3", i, rd, lat, lw[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    logic [15:0] er;
    model_apply(1'b0, 1'b0, 1'b0, 11'h004, 16'h0, er);
    req = 1'b1; we = 1'b0; size = 1'b0; sign = 1'b0; addr = 11'h004; wdata = 16'h0;
    // Held req: three busy cycles, one idle cycle (re-accept), then three more busy cycles.
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) dones++;
      checks++;
      if (ready !== (c % 4 == 0) || done !== (c % 4 == 3)) begin
        failures++;
        $display("FAIL held_req_c%0d: ready=%b done=%b want %b %b", c, ready, done,
                 (c % 4 == 0), (c % 4 == 3));
      end
      if (c == 3 || c == 7) begin
        checks++;
        if (rdata !== er) begin
          failures++;
          $display("FAIL held_req_data_c%0d: got %h want %h", c, rdata, er);
        end
      end
      if (c == 7) req = 1'b0;
    end
    checks++;
    if (dones !== 2) begin
      failures++;
      $display("FAIL held_req_count: dones=%0d want 2", dones);
    end
  endtask

  task automatic test_reset_mid_op();
    int wcnt = 0;
    int lat, wc, br; logic lk, io; logic [15:0] rd, er; logic [AW-1:0] ma;
    req = 1'b1; we = 1'b1; size = 1'b1; sign = 1'b0; addr = 11'h000; wdata = 16'h0055;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = 16'h0;
    #1;
    checks++;
    if (!(ready === 1'b1 && done === 1'b0 && mem_we === 1'b0 && rdata === exp_rdata &&
          mem_addr === '0 && mem_wdata === 16'h0)) begin
      failures++;
      $display("FAIL reset_async: ready=%b done=%b we=%b rdata=%h maddr=%h mwdata=%h",
               ready, done, mem_we, rdata, mem_addr, mem_wdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we) wcnt++;
    end
    reset = 1'b1;
    checks++;
    if (wcnt !== 0 || bram[0] !== ref_mem[0]) begin
      failures++;
      $display("FAIL reset_abort: we_pulses=%0d mem0=%h want 0 %h", wcnt, bram[0], ref_mem[0]);
    end
    model_apply(1'b0, 1'b0, 1'b0, 11'h000, 16'h0, er);
    do_op(1'b0, 1'b0, 1'b0, 11'h000, 16'h0, lat, wc, br, lk, rd, ma, io);
    checks++;
    if (rd !== 16'h000F || lat !== 3) begin
      failures++;
      $display("FAIL reset_reload: rdata=%h lat=%0d want 000f 3", rd, lat);
    end
  endtask

  task automatic test_top_addr();
    int lat, wc, br; logic lk, io; logic [15:0] rd, er; logic [AW-1:0] ma;
    model_apply(1'b1, 1'b0, 1'b0, 11'h7FE, 16'h1234, er);
    do_op(1'b1, 1'b0, 1'b0, 11'h7FE, 16'h1234, lat, wc, br, lk, rd, ma, io);
    checks++;
    if (ma !== 10'h3FF || wc !== 1) begin
      failures++;
      $display("FAIL top_store: mem_addr=%h we=%0d want 3ff 1", ma, wc);
    end
    model_apply(1'b0, 1'b0, 1'b0, 11'h7FE, 16'h0, er);
    do_op(1'b0, 1'b0, 1'b0, 11'h7FE, 16'h0, lat, wc, br, lk, rd, ma, io);
    checks++;
    if (ma !== 10'h3FF || rd !== 16'h1234) begin
      failures++;
      $display("FAIL top_load: mem_addr=%h rdata=%h want 3ff 1234", ma, rd);
    end
  endtask

  task automatic test_random();
    int lat, wc, br; logic lk, io; logic [15:0] rd, er; logic [AW-1:0] ma;
    logic o_we, o_size, o_sign;
    logic [AW:0] o_addr;
    logic [15:0] o_wdata;
    int w;
    for (int n = 0; n < 60; n++) begin
      o_we    = 1'($urandom_range(0, 1));
      o_size  = 1'($urandom_range(0, 1));
      o_sign  = 1'($urandom_range(0, 1));
      w       = $urandom_range(0, 1) ? $urandom_range(0, 5) : $urandom_range(WORDS - 3, WORDS - 1);
      o_addr  = {w[AW-1:0], 1'($urandom_range(0, 1))};
      o_wdata = 16'($urandom);
      model_apply(o_we, o_size, o_sign, o_addr, o_wdata, er);
      do_op(o_we, o_size, o_sign, o_addr, o_wdata, lat, wc, br, lk, rd, ma, io);
      checks++;
      if (lat !== ((o_we && !o_size) ? 1 : 3) || wc !== (o_we ? 1 : 0) || br !== 0 ||
          lk || !io || ma !== w[AW-1:0]) begin
        failures++;
        $display("FAIL rand_%0d_ctl: we=%b size=%b lat=%0d wpulses=%0d busyrdy=%0d leak=%b idle=%b maddr=%h want_w=%h",
                 n, o_we, o_size, lat, wc, br, lk, io, ma, w[AW-1:0]);
      end
      checks++;
      if (rd !== er || bram[w] !== ref_mem[w]) begin
        failures++;
        $display("FAIL rand_%0d_data: rdata=%h mem=%h want %h %h", n, rd, bram[w], er, ref_mem[w]);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    req = 1'b0; we = 1'b0; size = 1'b0; sign = 1'b0; addr = '0; wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    exp_rdata = 16'h0;
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = i[AW-1:0];
      bd_data = 16'($urandom);
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_byte_load_sign();
    test_back_to_back();
    test_reset_mid_op();
    test_top_addr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
